// File: rtl/seq_divider.sv
`default_nettype none
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0]   work_q, work_d;
    logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
    logic                    zero_q, zero_d;
    logic [DIVISOR_W-1:0]    prem_q, prem_d;
    logic [DIVIDEND_W-1:0]   quo_q, quo_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic                    dbz_q, dbz_d;

    // The shifted partial remainder is one bit wider than the divisor so the
    // compare sees the carried-out bit; after restoring it is always < divisor.
    logic [DIVISOR_W:0]      w_shifted;
    logic                    w_fits;
    logic [DIVISOR_W-1:0]    w_diff;
    logic [DIVISOR_W-1:0]    w_prem_next;
    logic [DIVIDEND_W-1:0]   w_work_next;

    always_comb begin
        w_shifted   = {prem_q, work_q[DIVIDEND_W-1]};
        w_fits      = (w_shifted >= {1'b0, dvs_q});
        w_diff      = w_shifted[DIVISOR_W-1:0] - dvs_q;
        w_prem_next = w_fits ? w_diff : w_shifted[DIVISOR_W-1:0];
        w_work_next = {work_q[DIVIDEND_W-2:0], w_fits};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    work_d  = dividend;
                    dvs_d   = divisor;
                    zero_d  = (divisor == '0);
                    prem_d  = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                work_d = w_work_next;
                prem_d = w_prem_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quo_d   = zero_q ? '1 : w_work_next;
                    rem_d   = w_prem_next;
                    dbz_d   = zero_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
